// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf : elastic pipeline-stage register (valid/ready FIFO).
//
// Carries one packed stage bundle of WIDTH bits across a pipeline boundary.
// DEPTH entries let upstream keep issuing while downstream stalls; flush kills
// every buffered entry at the next edge (mispredict / trap).
//
// Optional build macro: PIPE_STAGE_BUF_BYPASS_EN
//   defined   -> an empty buffer forwards in_data straight to out_data in the
//                same cycle when downstream is ready (0-cycle latency,
//                combinational in->out path).
//   undefined -> registered only, minimum latency 1 cycle.
//
// Ports
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   flush            synchronous kill of all buffered entries
//   in_valid/ready   upstream handshake, in_data = bundle offered
//   out_valid/ready  downstream handshake, out_data = head bundle (0 if none)
//   count            number of valid entries 0..DEPTH
//   full, empty      count == DEPTH, count == 0
// ---------------------------------------------------------------------------
module pipe_stage_buf #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   localparam int             PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0]  CMAX = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             push, pop, byp;

   assign full     = (count == CMAX);
   assign empty    = (count == '0);
   // in_ready deliberately ignores out_ready: no out_ready -> in_ready path.
   assign in_ready = !full;

`ifdef PIPE_STAGE_BUF_BYPASS_EN
   // Empty buffer and a ready consumer: hand the bundle straight through.
   assign byp = empty & in_valid & out_ready & !flush;
`else
   assign byp = 1'b0;
`endif

   // A bypassed bundle is consumed in flight, so it is neither stored nor popped.
   assign push      = in_valid & in_ready & !flush & !byp;
   assign pop       = !empty & out_ready & !flush;
   assign out_valid = !empty | byp;

   // Zero when nothing is presented so the next stage sees deterministic data.
   always_comb begin
      out_data = '0;
      if (!empty)
         out_data = mem[rd_ptr];
`ifdef PIPE_STAGE_BUF_BYPASS_EN
      else if (byp)
         out_data = in_data;
`endif
   end

   // Storage is not reset; only pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_data;
   end

   // Pointers wrap by explicit compare, so DEPTH need not be a power of two.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
